// File: rtl/operand_fetch_if.sv
// Operand fetch bus bundle: start/operand request, register-file port,
// RAM read port and the B-operand valid/ready handshake toward the ALU.
interface operand_fetch_if;
  // request side
  logic        start;
  logic [1:0]  mode;
  logic [31:0] litsrc;
  logic [7:0]  src_addr;
  // register-file read port
  logic        gpr_re;
  logic [3:0]  gpr_addr;
  logic [31:0] gpr_rdata;
  // RAM read port
  logic        ram_req;
  logic [7:0]  ram_addr;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  // B operand handshake
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic        err;
  logic        busy;

  // The fetch unit masters the GPR/RAM reads and drives the operand
  modport master (
    input  start, mode, litsrc, src_addr,
    input  gpr_rdata, ram_ack, ram_rdata, b_ready,
    output gpr_re, gpr_addr, ram_req, ram_addr,
    output b_valid, b_data, err, busy
  );

  // Surrounding system: issues requests, serves reads, consumes the operand
  modport slave (
    output start, mode, litsrc, src_addr,
    output gpr_rdata, ram_ack, ram_rdata, b_ready,
    input  gpr_re, gpr_addr, ram_req, ram_addr,
    input  b_valid, b_data, err, busy
  );
endinterface

// File: rtl/operand_fetch.sv
// Fetches one ALU B operand from an immediate literal, a GPR or RAM and
// presents it on a valid/ready handshake. All outputs are registered.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | waiting for start; only state where start is sampled
//   GPR_RD   | one-cycle register-file read strobe
//   GPR_CAP  | capture gpr_rdata (valid one cycle after gpr_re)
//   RAM_WAIT | ram_req held; waits for ram_ack or timeout down-counter
//   HOLD     | b_valid high, b_data/err frozen until b_ready
module operand_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GPR_RD   = 3'd1,
    GPR_CAP  = 3'd2,
    RAM_WAIT = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // Counter loads TIMEOUT-1 so that terminal count 0 marks the last
  // RAM_WAIT cycle, giving exactly TIMEOUT cycles of ram_req.
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmr;

  // Single FSM register block: next state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= 8'd0;
      bus.gpr_re   <= 1'b0;
      bus.gpr_addr <= 4'd0;
      bus.ram_req  <= 1'b0;
      bus.ram_addr <= 8'd0;
      bus.b_valid  <= 1'b0;
      bus.b_data   <= 32'd0;
      bus.err      <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.mode == 2'b00) begin
              bus.b_data  <= bus.litsrc;
              bus.err     <= 1'b0;
              bus.b_valid <= 1'b1;
              state       <= HOLD;
            end else if (bus.mode == 2'b01) begin
              bus.ram_req  <= 1'b1;
              bus.ram_addr <= bus.src_addr;
              tmr          <= TMR_LOAD;
              state        <= RAM_WAIT;
            end else begin
              bus.gpr_re   <= 1'b1;
              bus.gpr_addr <= bus.src_addr[3:0];
              state        <= GPR_RD;
            end
          end
        end

        GPR_RD: begin
          bus.gpr_re <= 1'b0;
          state      <= GPR_CAP;
        end

        GPR_CAP: begin
          bus.b_data  <= bus.gpr_rdata;
          bus.err     <= 1'b0;
          bus.b_valid <= 1'b1;
          state       <= HOLD;
        end

        RAM_WAIT: begin
          // ack is checked before terminal count so a last-cycle ack wins
          if (bus.ram_ack) begin
            bus.ram_req <= 1'b0;
            bus.b_data  <= bus.ram_rdata;
            bus.err     <= 1'b0;
            bus.b_valid <= 1'b1;
            tmr         <= 8'd0;
            state       <= HOLD;
          end else if (tmr == 8'd0) begin
            bus.ram_req <= 1'b0;
            bus.b_data  <= 32'd0;
            bus.err     <= 1'b1;
            bus.b_valid <= 1'b1;
            state       <= HOLD;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        HOLD: begin
          if (bus.b_ready) begin
            bus.b_valid <= 1'b0;
            bus.err     <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          tmr         <= 8'd0;
          bus.gpr_re  <= 1'b0;
          bus.ram_req <= 1'b0;
          bus.b_valid <= 1'b0;
          bus.err     <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a scoreboard of expected operands.
module tb_operand_fetch;

  logic clk;
  logic rst_n;

  operand_fetch_if ifc ();

  operand_fetch #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // free-running clock, 10 time units
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // called in a cycle where b_valid && b_ready completes a transfer
  task automatic sb_pop(input string tag);
    exp_t x;
    chk({tag, "_sb_avail"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk({tag, "_data"}, ifc.b_data, x.data);
      chk({tag, "_err"}, 32'(ifc.err), 32'(x.err));
    end
  endtask

  // directed sequence
  initial begin
    logic [31:0] held;
    rst_n         = 1'b0;
    ifc.start     = 1'b0;
    ifc.mode      = 2'b00;
    ifc.litsrc    = 32'd0;
    ifc.src_addr  = 8'd0;
    ifc.gpr_rdata = 32'd0;
    ifc.ram_ack   = 1'b0;
    ifc.ram_rdata = 32'd0;
    ifc.b_ready   = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_b_valid", 32'(ifc.b_valid), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_gpr_re", 32'(ifc.gpr_re), 32'd0);
    chk("rst_ram_req", 32'(ifc.ram_req), 32'd0);
    chk("rst_b_data", ifc.b_data, 32'd0);
    chk("rst_gpr_addr", 32'(ifc.gpr_addr), 32'd0);
    chk("rst_ram_addr", 32'(ifc.ram_addr), 32'd0);

    // immediate, start presented in the first cycle after release
    rst_n      = 1'b1;
    ifc.start  = 1'b1;
    ifc.mode   = 2'b00;
    ifc.litsrc = 32'hDEADBEEF;
    ifc.b_ready = 1'b1;
    push_exp(32'hDEADBEEF, 1'b0);
    tick();
    ifc.start = 1'b0;
    chk("imm_valid_n1", 32'(ifc.b_valid), 32'd1);
    chk("imm_busy_n1", 32'(ifc.busy), 32'd1);
    sb_pop("imm");
    tick();
    chk("imm_busy_n2", 32'(ifc.busy), 32'd0);
    chk("imm_valid_n2", 32'(ifc.b_valid), 32'd0);

    // register mode; b_ready already high must not shorten latency
    ifc.start     = 1'b1;
    ifc.mode      = 2'b10;
    ifc.src_addr  = 8'h05;
    ifc.gpr_rdata = 32'hFFFF0000;
    push_exp(32'h12345678, 1'b0);
    tick();
    ifc.start = 1'b0;
    chk("gpr_re_n1", 32'(ifc.gpr_re), 32'd1);
    chk("gpr_addr_n1", 32'(ifc.gpr_addr), 32'd5);
    chk("gpr_valid_n1", 32'(ifc.b_valid), 32'd0);
    ifc.gpr_rdata = 32'hBAD0BAD0;
    tick();
    chk("gpr_re_n2", 32'(ifc.gpr_re), 32'd0);
    chk("gpr_valid_n2", 32'(ifc.b_valid), 32'd0);
    ifc.gpr_rdata = 32'h12345678;
    tick();
    ifc.gpr_rdata = 32'hBAD1BAD1;
    chk("gpr_valid_n3", 32'(ifc.b_valid), 32'd1);
    sb_pop("gpr");
    tick();
    chk("gpr_valid_n4", 32'(ifc.b_valid), 32'd0);
    chk("gpr_busy_n4", 32'(ifc.busy), 32'd0);

    // direct with ack in N+3; stray ack in IDLE must be ignored
    ifc.start    = 1'b1;
    ifc.mode     = 2'b01;
    ifc.src_addr = 8'h40;
    ifc.ram_ack  = 1'b1;
    ifc.ram_rdata = 32'h11111111;
    push_exp(32'hCAFEF00D, 1'b0);
    tick();
    ifc.start   = 1'b0;
    ifc.ram_ack = 1'b0;
    chk("ram_req_n1", 32'(ifc.ram_req), 32'd1);
    chk("ram_addr_n1", 32'(ifc.ram_addr), 32'h40);
    tick();
    chk("ram_req_n2", 32'(ifc.ram_req), 32'd1);
    chk("ram_valid_n2", 32'(ifc.b_valid), 32'd0);
    tick();
    chk("ram_req_n3", 32'(ifc.ram_req), 32'd1);
    ifc.ram_ack   = 1'b1;
    ifc.ram_rdata = 32'hCAFEF00D;
    tick();
    ifc.ram_ack   = 1'b0;
    ifc.ram_rdata = 32'd0;
    chk("ram_req_n4", 32'(ifc.ram_req), 32'd0);
    chk("ram_valid_n4", 32'(ifc.b_valid), 32'd1);
    sb_pop("ram");
    tick();
    chk("ram_valid_n5", 32'(ifc.b_valid), 32'd0);

    // timeout: no ack, ram_req for exactly TIMEOUT=4 cycles
    ifc.start    = 1'b1;
    ifc.mode     = 2'b01;
    ifc.src_addr = 8'h33;
    ifc.b_ready  = 1'b0;
    push_exp(32'd0, 1'b1);
    tick();
    ifc.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_req_c%0d", i), 32'(ifc.ram_req), 32'd1);
      chk($sformatf("to_valid_c%0d", i), 32'(ifc.b_valid), 32'd0);
      tick();
    end
    chk("to_req_end", 32'(ifc.ram_req), 32'd0);
    chk("to_valid_end", 32'(ifc.b_valid), 32'd1);
    ifc.b_ready = 1'b1;
    sb_pop("to");
    tick();
    chk("to_valid_after", 32'(ifc.b_valid), 32'd0);

    // ack in the final timeout cycle wins
    ifc.start    = 1'b1;
    ifc.mode     = 2'b01;
    ifc.src_addr = 8'h21;
    push_exp(32'h0F0FA5A5, 1'b0);
    tick();
    ifc.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("last_req_c%0d", i), 32'(ifc.ram_req), 32'd1);
      tick();
    end
    chk("last_req_c4", 32'(ifc.ram_req), 32'd1);
    ifc.ram_ack   = 1'b1;
    ifc.ram_rdata = 32'h0F0FA5A5;
    tick();
    ifc.ram_ack   = 1'b0;
    ifc.ram_rdata = 32'd0;
    chk("last_req_end", 32'(ifc.ram_req), 32'd0);
    chk("last_valid", 32'(ifc.b_valid), 32'd1);
    sb_pop("last");
    tick();

    // backpressure: 5 stalled HOLD cycles with start pulsed, then accept
    ifc.start   = 1'b1;
    ifc.mode    = 2'b00;
    ifc.litsrc  = 32'h5A5A1234;
    ifc.b_ready = 1'b0;
    push_exp(32'h5A5A1234, 1'b0);
    tick();
    held = 32'h5A5A1234;
    for (int i = 1; i <= 5; i++) begin
      ifc.start  = (i % 2) == 1;
      ifc.litsrc = 32'h77770000 + 32'(i);
      ifc.mode   = 2'b00;
      chk($sformatf("bp_valid_c%0d", i), 32'(ifc.b_valid), 32'd1);
      chk($sformatf("bp_data_c%0d", i), ifc.b_data, held);
      tick();
    end
    ifc.start   = 1'b1;
    ifc.b_ready = 1'b1;
    chk("bp_valid_c6", 32'(ifc.b_valid), 32'd1);
    sb_pop("bp");
    tick();
    ifc.start = 1'b0;
    chk("bp_idle_valid", 32'(ifc.b_valid), 32'd0);
    chk("bp_idle_busy", 32'(ifc.busy), 32'd0);

    // reset two cycles into RAM_WAIT, then a late ack
    ifc.start    = 1'b1;
    ifc.mode     = 2'b01;
    ifc.src_addr = 8'h77;
    tick();
    ifc.start = 1'b0;
    tick();
    chk("rm_req_pre", 32'(ifc.ram_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_req_async", 32'(ifc.ram_req), 32'd0);
    chk("rm_busy_async", 32'(ifc.busy), 32'd0);
    tick();
    rst_n         = 1'b1;
    ifc.ram_ack   = 1'b1;
    ifc.ram_rdata = 32'hBADBAD00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("rm_valid_c%0d", i), 32'(ifc.b_valid), 32'd0);
      chk($sformatf("rm_req_c%0d", i), 32'(ifc.ram_req), 32'd0);
    end
    ifc.ram_ack = 1'b0;

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum RAM_WAIT cycles before abort, legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to fetch one B operand; sampled only in IDLE.
REQ-005 mode  input  2  addressing mode: 00 immediate, 01 direct (RAM), 1x register (GPR).
REQ-006 litsrc  input  32  literal operand for immediate mode.
REQ-007 src_addr  input  8  RAM address (direct mode); bits [3:0] give the GPR index (register mode).
REQ-008 gpr_re  output  1  register-file read strobe.
REQ-009 gpr_addr  output  4  register-file read index.
REQ-010 gpr_rdata  input  32  register-file data, valid the cycle after gpr_re.
REQ-011 ram_req  output  1  RAM read request, held until ram_ack or timeout.
REQ-012 ram_addr  output  8  RAM read address, stable while ram_req=1.
REQ-013 ram_ack  input  1  RAM read completion; ram_rdata valid in the same cycle.
REQ-014 ram_rdata  input  32  RAM read data.
REQ-015 b_valid  output  1  operand available on b_data.
REQ-016 b_ready  input  1  consumer accepts the operand.
REQ-017 b_data  output  32  fetched operand for the ALU B bus.
REQ-018 err  output  1  operand is invalid because the RAM read timed out; valid only while b_valid=1.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The block SHALL implement states IDLE, GPR_RD, GPR_CAP, RAM_WAIT and HOLD, each encoded as a single register value.
REQ-021 In IDLE with start=1, the block SHALL register mode, litsrc and src_addr, then go to: HOLD with b_data=litsrc (mode 00), RAM_WAIT (mode 01), or GPR_RD (mode 1x).
REQ-022 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-023 GPR_RD SHALL last exactly one cycle, with gpr_re=1 and gpr_addr=src_addr[3:0], and SHALL then go to GPR_CAP.
REQ-024 GPR_CAP SHALL capture gpr_rdata into b_data and go to HOLD after one cycle.
REQ-025 RAM_WAIT SHALL drive ram_req=1 and ram_addr=src_addr, and count the cycles spent in the state.
REQ-026 ram_ack=1 in RAM_WAIT SHALL capture ram_rdata into b_data, set err=0 and go to HOLD; ram_req SHALL drop in the cycle after ram_ack.
REQ-027 If ram_ack has not been seen after TIMEOUT cycles in RAM_WAIT, the block SHALL set b_data=0 and err=1, drop ram_req, and go to HOLD.
REQ-028 If ram_ack arrives in the final timeout cycle, the ack SHALL win.
REQ-029 HOLD SHALL assert b_valid=1 and keep b_data and err stable until b_ready=1, then return to IDLE.
REQ-030 b_ready=1 in HOLD SHALL complete the transfer in that same cycle.
REQ-031 start SHALL be ignored outside IDLE, including in the HOLD cycle that completes the transfer.
REQ-032 ram_ack outside RAM_WAIT and gpr_rdata outside GPR_CAP SHALL be ignored.
REQ-033 Latency from the accepting start cycle N to the first b_valid cycle SHALL be:
  - immediate: N+1
  - register: N+3
  - direct: (ack cycle)+1, with ram_req first asserted in cycle N+1
REQ-034 b_ready held at 1 before b_valid rises SHALL NOT shorten this latency.
REQ-035 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-036 While rst_n=0, the block SHALL immediately force state=IDLE and b_data=0, and drive every control output (b_valid, err, busy, gpr_re, ram_req) to 0.
REQ-037 While rst_n=0, the block SHALL drive gpr_addr=0, ram_addr=0, and the timeout counter to 0.
REQ-038 Reset asserted mid-operation SHALL abandon the fetch, drop ram_req without waiting for ram_ack, and discard any pending operand.
REQ-039 The first start after reset release SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-040 Immediate: start, mode=00, litsrc=0xDEADBEEF, b_ready=1 -> b_valid=1 in cycle N+1, b_data=0xDEADBEEF, err=0, busy=0 in cycle N+2.
REQ-041 Register: start, mode=10, src_addr=0x05, gpr_rdata=0x12345678 -> gpr_re=1 and gpr_addr=5 in N+1, b_valid=1 in N+3, b_data=0x12345678.
REQ-042 Direct with ack delay 3: src_addr=0x40, ram_ack in N+3 with ram_rdata=0xCAFEF00D -> ram_req=1 in cycles N+1..N+3, b_valid=1 in N+4, b_data=0xCAFEF00D.
REQ-043 Timeout: TIMEOUT=4, mode=01, ram_ack never asserted -> ram_req=1 for exactly 4 cycles, then b_valid=1, err=1, b_data=0.
REQ-044 Backpressure: b_ready=0 for 5 cycles in HOLD, then 1, with start pulsed during HOLD -> b_data stable for all 6 cycles, start ignored, return to IDLE.
REQ-045 Reset mid-fetch: rst_n=0 two cycles into RAM_WAIT, then ram_ack arrives after release -> ram_req=0 immediately, the late ack is ignored, and b_valid stays 0.
